// File: rtl/fpga1_transmitter_if.sv
// rtl/fpga1_transmitter_if.sv - local word stream and FPGA1->FPGA2 req/ack link signals
interface fpga1_transmitter_if;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] data_out;
   logic        req_out;
   logic        rdy_in;
   logic        ack_in;

   modport master (
      output s_data, s_valid, rdy_in, ack_in,
      input  s_ready, data_out, req_out
   );

   modport slave (
      input  s_data, s_valid, rdy_in, ack_in,
      output s_ready, data_out, req_out
   );
endinterface

// File: rtl/fpga1_transmitter.sv
// rtl/fpga1_transmitter.sv - FIFO-buffered 4-phase req/ack sender for the FPGA1->FPGA2 link
module fpga1_transmitter #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fpga1_transmitter_if.slave   link,
   output logic                 busy,
   output logic [15:0]          tx_count,
   output logic                 timeout_err,
   input  logic                 err_clr
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, SETUP, REQ, RELEASE} state_t;

   state_t         state, state_nxt;
   logic [1:0]     rdy_sync, ack_sync;
   logic           rdy_s, ack_s, rdy_d, rdy_rise;
   logic [31:0]    mem [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [AW:0]    count;
   logic           push, pop, load, req_set, req_clr, tmo_clr, tmo_inc, tmo_hit;
   logic [TW-1:0]  tmo_cnt;
   logic [31:0]    data_q;
   logic           req_q;

   assign rdy_s    = rdy_sync[1];
   assign ack_s    = ack_sync[1];
   assign rdy_rise = rdy_s & ~rdy_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_sync <= 2'b00;
         ack_sync <= 2'b00;
         rdy_d    <= 1'b0;
      end else begin
         rdy_sync <= {rdy_sync[0], link.rdy_in};
         ack_sync <= {ack_sync[0], link.ack_in};
         rdy_d    <= rdy_s;
      end
   end

   // s_ready depends only on the registered count, never on this cycle's pop
   assign link.s_ready = (count != (AW+1)'(DEPTH));
   assign push         = link.s_valid && link.s_ready;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= link.s_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      load      = 1'b0;
      req_set   = 1'b0;
      req_clr   = 1'b0;
      tmo_clr   = 1'b0;
      tmo_inc   = 1'b0;
      tmo_hit   = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               load      = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            req_set   = 1'b1;
            tmo_clr   = 1'b1;
            state_nxt = REQ;
         end
         REQ: begin
            if (ack_s) begin
               pop       = 1'b1;
               req_clr   = 1'b1;
               state_nxt = RELEASE;
            end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
               // abandon without popping so the same word goes out again
               tmo_hit   = 1'b1;
               req_clr   = 1'b1;
               state_nxt = RELEASE;
            end else if (rdy_rise) begin
               tmo_clr = 1'b1;
            end else begin
               tmo_inc = 1'b1;
            end
         end
         RELEASE: begin
            if (!ack_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q      <= '0;
         req_q       <= 1'b0;
         tmo_cnt     <= '0;
         tx_count    <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (load)         data_q <= mem[rd_ptr];
         if (req_set)      req_q  <= 1'b1;
         else if (req_clr) req_q  <= 1'b0;
         if (tmo_clr)      tmo_cnt <= '0;
         else if (tmo_inc) tmo_cnt <= tmo_cnt + TW'(1);
         if (pop)          tx_count <= tx_count + 16'd1;
         if (tmo_hit)      timeout_err <= 1'b1;
         else if (err_clr) timeout_err <= 1'b0;
      end
   end

   assign link.data_out = data_q;
   assign link.req_out  = req_q;
   assign busy          = (state != IDLE) || (count != '0);
endmodule

// File: tb/tb_fpga1_transmitter.sv
// tb/tb_fpga1_transmitter.sv - directed vectors and handshake sequences for fpga1_transmitter
module tb_fpga1_transmitter;
   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        busy;
   logic [15:0] tx_count;
   logic        timeout_err;
   logic        err_clr;

   fpga1_transmitter_if link();

   fpga1_transmitter #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .link        (link.slave),
      .busy        (busy),
      .tx_count    (tx_count),
      .timeout_err (timeout_err),
      .err_clr     (err_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        exp_ready;
   } vec_t;

   vec_t        vecs [DEPTH+2];
   int          tests = 0;
   int          fails = 0;
   bit          resp_en = 1'b0;
   int          wcnt = 0;
   logic [31:0] rx_q [$];
   logic        req_prev = 1'b0;
   logic [31:0] held = '0;
   int          n;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] d);
      @(negedge clk);
      link.s_valid = 1'b1;
      link.s_data  = d;
      @(negedge clk);
      link.s_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      resp_en      = 1'b0;
      link.s_valid = 1'b0;
      err_clr      = 1'b0;
      repeat (2) @(negedge clk);
      rx_q.delete();
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // FPGA2 responder: rdy on seeing req, ack 4 cycles later, drop both once req falls
   initial begin
      link.rdy_in = 1'b0;
      link.ack_in = 1'b0;
      forever begin
         @(negedge clk);
         if (resp_en && link.req_out) begin
            if (!link.ack_in) begin
               link.rdy_in = 1'b1;
               if (wcnt == 3) begin
                  link.ack_in = 1'b1;
                  rx_q.push_back(link.data_out);
               end else begin
                  wcnt++;
               end
            end
         end else begin
            link.rdy_in = 1'b0;
            link.ack_in = 1'b0;
            wcnt        = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (link.req_out && req_prev) check("data_stable", link.data_out, held);
         if (link.req_out && !req_prev) held = link.data_out;
         req_prev = link.req_out;
      end
   end

   initial begin
      for (int i = 0; i < DEPTH + 2; i++) begin
         vecs[i].data      = 32'(i);
         vecs[i].exp_ready = (i < DEPTH);
      end
      rst_n        = 1'b0;
      err_clr      = 1'b0;
      link.s_valid = 1'b0;
      link.s_data  = '0;
      repeat (2) @(negedge clk);
      check("rst_data_out", link.data_out, 32'h0);
      check("rst_req_out", 32'(link.req_out), 32'h0);
      check("rst_s_ready", 32'(link.s_ready), 32'h1);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_tx_count", 32'(tx_count), 32'h0);
      check("rst_timeout_err", 32'(timeout_err), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // single word with push-to-req latency
      resp_en = 1'b1;
      push(32'hDEADBEEF);
      check("single_req_n0", 32'(link.req_out), 32'h0);
      @(negedge clk);
      check("single_setup_data", link.data_out, 32'hDEADBEEF);
      check("single_req_n1", 32'(link.req_out), 32'h0);
      @(negedge clk);
      check("single_req_n2", 32'(link.req_out), 32'h1);
      repeat (30) @(negedge clk);
      check("single_rx_count", 32'(rx_q.size()), 32'd1);
      check("single_rx_data", rx_q[0], 32'hDEADBEEF);
      check("single_tx_count", 32'(tx_count), 32'd1);
      check("single_busy", 32'(busy), 32'h0);

      // fill FIFO from the vector table with no responder
      do_reset();
      for (int i = 0; i < DEPTH + 2; i++) begin
         @(negedge clk);
         check($sformatf("fill_s_ready_%0d", i), 32'(link.s_ready), 32'(vecs[i].exp_ready));
         link.s_valid = 1'b1;
         link.s_data  = vecs[i].data;
      end
      @(negedge clk);
      link.s_valid = 1'b0;
      repeat (40) @(negedge clk);
      check("fill_full", 32'(link.s_ready), 32'h0);
      check("fill_tmo_err", 32'(timeout_err), 32'h1);
      resp_en = 1'b1;
      repeat (400) @(negedge clk);
      check("fill_rx_count", 32'(rx_q.size()), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) check($sformatf("fill_rx_%0d", i), rx_q[i], vecs[i].data);
      check("fill_tx_count", 32'(tx_count), 32'(DEPTH));
      check("fill_busy", 32'(busy), 32'h0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("fill_err_clr", 32'(timeout_err), 32'h0);

      // timeout, resend, set-beats-clear
      do_reset();
      push(32'hA5A50001);
      for (int i = 0; i < 20 && !link.req_out; i++) @(negedge clk);
      check("tmo_req_rise", 32'(link.req_out), 32'h1);
      n = 0;
      while (link.req_out && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("tmo_req_cycles", 32'(n), 32'(TIMEOUT));
      check("tmo_err_set", 32'(timeout_err), 32'h1);
      check("tmo_busy", 32'(busy), 32'h1);
      check("tmo_s_ready", 32'(link.s_ready), 32'h1);
      for (int i = 0; i < 20 && !link.req_out; i++) @(negedge clk);
      check("tmo_resend_req", 32'(link.req_out), 32'h1);
      check("tmo_resend_data", link.data_out, 32'hA5A50001);
      err_clr = 1'b1;
      n = 0;
      while (link.req_out && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("tmo_req_cycles2", 32'(n), 32'(TIMEOUT));
      check("tmo_set_wins", 32'(timeout_err), 32'h1);
      @(negedge clk);
      check("tmo_clr", 32'(timeout_err), 32'h0);
      err_clr = 1'b0;
      resp_en = 1'b1;
      repeat (60) @(negedge clk);
      check("tmo_rx_count", 32'(rx_q.size()), 32'd1);
      check("tmo_rx_data", rx_q[0], 32'hA5A50001);
      check("tmo_tx_count", 32'(tx_count), 32'd1);
      check("tmo_err_final", 32'(timeout_err), 32'h0);

      // push held against a full FIFO while the head word is acked
      do_reset();
      for (int i = 0; i < DEPTH; i++) push(32'hB0 + 32'(i));
      check("simul_full", 32'(link.s_ready), 32'h0);
      resp_en      = 1'b1;
      link.s_valid = 1'b1;
      link.s_data  = 32'h0BAD0008;
      for (int i = 0; i < 200 && tx_count == 16'd0; i++) @(negedge clk);
      check("simul_pop", 32'(tx_count), 32'd1);
      check("simul_ready_after_pop", 32'(link.s_ready), 32'h1);
      @(posedge clk);
      #1 link.s_valid = 1'b0;
      repeat (300) @(negedge clk);
      check("simul_rx_count", 32'(rx_q.size()), 32'(DEPTH + 1));
      for (int i = 0; i < DEPTH; i++) check($sformatf("simul_rx_%0d", i), rx_q[i], 32'hB0 + 32'(i));
      check("simul_rx_last", rx_q[DEPTH], 32'h0BAD0008);
      check("simul_tx_count", 32'(tx_count), 32'(DEPTH + 1));

      // asynchronous reset while req is high
      do_reset();
      push(32'hC0FFEE00);
      for (int i = 0; i < 20 && !link.req_out; i++) @(negedge clk);
      check("rstmid_req_high", 32'(link.req_out), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_req_out", 32'(link.req_out), 32'h0);
      check("rstmid_data_out", link.data_out, 32'h0);
      check("rstmid_s_ready", 32'(link.s_ready), 32'h1);
      check("rstmid_busy", 32'(busy), 32'h0);
      check("rstmid_tx_count", 32'(tx_count), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rx_q.delete();
      resp_en = 1'b1;
      push(32'h12345678);
      repeat (40) @(negedge clk);
      check("rstmid_rx_count", 32'(rx_q.size()), 32'd1);
      check("rstmid_rx_data", rx_q[0], 32'h12345678);
      check("rstmid_tx_count2", 32'(tx_count), 32'd1);

      // transfer counter wrap
      force dut.tx_count = 16'hFFFF;
      @(negedge clk);
      release dut.tx_count;
      @(negedge clk);
      check("wrap_preload", 32'(tx_count), 32'h0000FFFF);
      push(32'h5A5A5A5A);
      repeat (40) @(negedge clk);
      check("wrap_tx_count", 32'(tx_count), 32'h0);
      check("wrap_rx_data", rx_q[rx_q.size() - 1], 32'h5A5A5A5A);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fpga1_transmitter.md
# fpga1_transmitter

Source side of the FPGA1→FPGA2 32-bit link; it sits directly upstream of the FPGA2 receiver. It buffers words from local FPGA1 logic in a small FIFO and sends each one across the board with a 4-phase req/ack handshake. The receiver's `rdy` and `ack` signals are asynchronous to `clk` and pass through 2-flop synchronizers. A stalled receiver raises a sticky timeout error, and the word is retried.

## Interface
- `DEPTH`, 8: FIFO depth in words; power of 2, ≥2.
- `TIMEOUT`, 1024: `clk` cycles in REQ without progress before abort; ≥4.
- `clk` input, 1: clock for FPGA 1.
- `rst_n` input, 1: asynchronous, active-low reset.
- `s_data` input, 32: word from local logic.
- `s_valid` input, 1: `s_data` valid.
- `s_ready` output, 1: FIFO not full.
- `data_out` output, 32: link data to FPGA 2.
- `req_out` output, 1: request to FPGA 2.
- `rdy_in` input, 1: ready from FPGA 2 (asynchronous).
- `ack_in` input, 1: acknowledge from FPGA 2 (asynchronous).
- `busy` output, 1: FSM not in IDLE, or FIFO not empty.
- `tx_count` output, 16: completed transfers; wraps at 0xFFFF→0.
- `timeout_err` output, 1: sticky timeout flag.
- `err_clr` input, 1: synchronous clear of `timeout_err`.

## Operation
- **Synchronizers.** `rdy_in` and `ack_in` each pass through 2 flops (reset 0). Only the synchronized copies (`rdy_s`, `ack_s`) are used.
- **FIFO.**
  - Push on `s_valid && s_ready`.
  - Pop only on a successful ack in REQ.
  - Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
  - `s_ready = (count != DEPTH)`.
  - Simultaneous push and pop leaves count unchanged. This is legal when full, but `s_ready` stays 0 that cycle (no combinational path from pop).
- **FSM** (registered outputs):
  - **IDLE:** `req_out`=0. If FIFO is non-empty: `data_out` ← FIFO head, go to SETUP.
  - **SETUP:** one cycle of data setup. `req_out` ← 1, clear the timeout counter, go to REQ.
  - **REQ:** `req_out`=1 and `data_out` held constant.
    - If `ack_s`=1: pop the FIFO, `tx_count`+1, `req_out` ← 0, go to RELEASE.
    - Otherwise, if the timeout counter reaches TIMEOUT−1: `timeout_err` ← 1, `req_out` ← 0, no pop, go to RELEASE. The same word is resent later.
    - Otherwise the counter increments. It is cleared on any cycle where `rdy_s` rises, because the receiver has engaged.
  - **RELEASE:** `req_out`=0. Wait for `ack_s`=0, then go to IDLE.
- **Error flag.** `err_clr` clears `timeout_err`. If a set and `err_clr` occur in the same cycle, the set wins.
- **Data stability.** `data_out` changes only in IDLE→SETUP, so it is stable from one cycle before `req_out` rises until RELEASE.

## Timing
- **Reset values.** All outputs 0 except `s_ready`=1: `data_out`=0, `req_out`=0, `busy`=0, `tx_count`=0, `timeout_err`=0. FIFO is empty, FSM is in IDLE, synchronizers are 0.
- **Latency from push to `req_out` high.** The first word is pushed at edge N and appears in the FIFO at N. Then:
  - N+1: FSM enters SETUP and `data_out` is valid.
  - N+2: `req_out`=1.
- **Ack path.** `ack_in` rises at edge M. Then:
  - `ack_s` goes high at M+2.
  - At the M+2 edge: `req_out`=0, pop, count increment.
- **Back-to-back words.** After `ack_s` falls, the FSM re-enters IDLE, then SETUP the next cycle. At least 2 cycles separate a `req_out` fall from the next rise.
- **Reset mid-transfer.** An asynchronous reset drops `req_out` immediately and flushes the FIFO. FPGA 2 then sees `req` low and returns to its idle state.
- **Ack glitch.** An `ack_s` high in IDLE or SETUP is ignored. The FSM still waits in REQ for `ack_s`=1; since ack is already high, it completes immediately. This is acceptable: FPGA 2 only raises ack after seeing `req`.

## Test plan
- **Single word.** Push 0xDEADBEEF; the responder model raises `rdy`, then `ack` 4 cycles after `req`, and drops `ack` after `req` falls. Expect: `req_out` high 2 cycles after the push, `data_out`=0xDEADBEEF stable throughout, `tx_count`=1, `busy`=0 at the end.
- **Fill FIFO.** Push DEPTH+2 words with no responder. Expect `s_ready`=0 after 8 pushes. Enable the responder; expect all 8 words in order (0..7), `tx_count`=8, and the 2 extra words never accepted.
- **Timeout.** Use TIMEOUT=16 and a responder that never acks. Expect `timeout_err`=1 and `req_out`=0 after 16 cycles in REQ, FIFO count unchanged, and the same word re-sent. Then enable `ack`; expect the word delivered once, `tx_count`=1, and `err_clr` clearing the flag.
- **Simultaneous push and pop.** With the FIFO full, an ack occurs in the same cycle as an `s_valid` push. Expect the push rejected (`s_ready`=0), count 8→7, and no data loss.
- **Reset mid-REQ.** Assert `rst_n`=0 while `req_out`=1. Expect `req_out`=0 asynchronously, all outputs at reset values, and a fresh push working after release.
- **Counter wrap.** Preload `tx_count`=0xFFFF via 65535 transfers (or a force). After one more transfer, expect `tx_count`=0.
